// File: rtl/sequence_pkg.sv
// Shared definitions for the 3-bit symbol sequence link (generator and detector).
// Both ends index the same symbol table so their notion of a frame cannot drift.
package sequence_pkg;

    localparam int SEQ_LEN = 8;
    localparam int DATA_W  = 3;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 3;

    localparam logic [DATA_W-1:0] IDLE_SYM = 3'b111;

    // Entry 0 sits in the least significant slot: frame is 001,101,110,000,110,110,011,101.
    localparam logic [SEQ_LEN-1:0][DATA_W-1:0] SEQ_SYMS = {
        3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001
    };

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/seq_symbol_rom.sv
// Frame symbol lookup, purely combinational (zero latency, no flow control).
// Index wraps naturally over the 8-entry frame.
module seq_symbol_rom
    import sequence_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] sym
);

    assign sym = SEQ_SYMS[idx];

endmodule

// File: rtl/sequence_generator.sv
// Frame source: emits the fixed 8-symbol frame repeat_cnt+1 times back-to-back, registered outputs.
// Symbol holds while data_ready is low; abort cancels without a done pulse.
module sequence_generator
    import sequence_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  repeat_cnt,
    input  logic              abort,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [CNT_W-1:0]    pass_q, pass_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic                valid_q, valid_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic [DATA_W-1:0]   rom_sym;

    // The ROM looks up the *next* index so the symbol lands in the data register with its index.
    seq_symbol_rom u_rom (
        .idx (idx_n),
        .sym (rom_sym)
    );

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        pass_n  = pass_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_n = SEND;
                    idx_n   = '0;
                    pass_n  = '0;
                    cnt_n   = repeat_cnt;
                end
            end
            SEND: begin
                // abort takes priority over a transfer on the same edge
                if (abort) begin
                    state_n = IDLE;
                end else if (valid_q && data_ready) begin
                    if (idx_q != IDX_W'(SEQ_LEN - 1)) begin
                        idx_n = idx_q + 1'b1;
                    end else if (pass_q != cnt_q) begin
                        pass_n = pass_q + 1'b1;
                        idx_n  = '0;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        valid_n = (state_n == SEND);
        busy_n  = (state_n == SEND);
        data_n  = valid_n ? rom_sym : IDLE_SYM;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            cnt_q   <= '0;
            data_q  <= IDLE_SYM;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            pass_q  <= pass_n;
            cnt_q   <= cnt_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Transmit side of the 3-bit symbol sequence link. On a start request, emits the fixed 8-symbol frame 001,101,110,000,110,110,011,101 one symbol per accepted transfer, for a programmable number of back-to-back passes. A downstream consumer, typically the sequence detector, applies valid/ready flow control. Used as the stimulus/source end of the same sequence protocol on-chip.

Parameters:
SEQ_LEN, 8, symbols per frame (fixed by protocol; not for override)
DATA_W, 3, symbol width in bits
CNT_W, 4, width of repeat_cnt
IDLE_SYM, 3'b111, value driven on data while data_valid=0

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request a transmission; sampled only in IDLE
repeat_cnt  input  CNT_W  passes minus one; latched with start (0 = one frame)
abort  input  1  synchronous cancel of an active transmission
data_ready  input  1  consumer accepts current symbol
data  output  DATA_W  current symbol
data_valid  output  1  data holds a valid symbol
busy  output  1  transmission in progress
done  output  1  one-cycle pulse after final symbol accepted

Behaviour:
- One clock domain; reset is asynchronous and active-low on reset_n. All state and outputs are registered.
- Reset values: data=IDLE_SYM, data_valid=0, busy=0, done=0, state=IDLE, symbol index=0, pass count=0.
- States: IDLE, SEND.
- IDLE: on a rising edge with start=1 and abort=0, latch repeat_cnt, clear index and pass count, and go to SEND. The next cycle has data_valid=1, data=symbol[0]=001 and busy=1.
- SEND: a transfer occurs on a rising edge with data_valid & data_ready. data and data_valid hold stable while data_ready=0; there is no timeout.
- On a transfer with index<7: index+1, and data=symbol[index+1] next cycle.
- On a transfer with index=7 and pass<latched count: pass+1, index wraps to 0, and data=001 next cycle. There is no bubble between frames.
- On a transfer with index=7 and pass=latched count: go to IDLE. Next cycle: data_valid=0, data=IDLE_SYM, busy=0, done=1 for exactly one cycle.
- With data_ready held at 1, the block emits 8*(repeat_cnt+1) consecutive valid cycles.
- abort=1 in SEND: go to IDLE next cycle with data_valid=0, busy=0. done is not pulsed. abort wins over a same-edge transfer.
- abort=1 in IDLE: no effect. start with abort on the same edge is ignored.
- start in SEND is ignored, and repeat_cnt changes mid-transmission have no effect.
- start is accepted in the cycle done is high (state is IDLE). The new frame's first symbol appears the following cycle, and done still deasserts.
- Reset mid-frame: outputs return to reset values immediately. No done pulse, and there is no resume.
- Index counter: 3 bits with natural wrap. The pass counter is CNT_W bits and is compared for equality against the latched value; it never overflows.

Decomposition:
- Package sequence_pkg: DATA_W, SEQ_LEN, CNT_W, IDLE_SYM, the 8-entry symbol constant array, and the state type (IDLE, SEND). The detector shares the same symbol array so that both ends agree.
- Sub-module seq_symbol_rom: combinational, 3-bit index in, DATA_W symbol out, driven from the package array. Everything else stays in sequence_generator.

Test Plan:
- Reset then idle: reset_n low 3 cycles, then high 5 cycles -> data=111, data_valid=0, busy=0, done=0 throughout.
- Single frame, ready=1: start at edge 0 with repeat_cnt=0 -> cycles 1..8 give data 001,101,110,000,110,110,011,101 with valid=1; cycle 9 has done=1, busy=0; a connected detector asserts sequence_found in cycle 8.
- Backpressure: single frame with data_ready=0 during cycles 3-5 -> symbol 110 held stable for 4 cycles, no symbol skipped or duplicated, done in cycle 12.
- Repeat: repeat_cnt=2, ready=1 -> 24 consecutive valid cycles (three frames, 001 directly after 101), a single done pulse in cycle 25; repeat_cnt changed mid-run has no effect.
- Abort and restart: abort at the 4th symbol -> valid drops next cycle with no done; start in the same cycle as a done pulse -> new frame begins the next cycle.
- Async reset: reset_n low mid-symbol (between edges) -> valid and busy drop immediately; after release, idle until a new start.
